mul_iter: RTL and testbench

MUL_ITER -- requirements
Module: mul_iter

---
 rtl/mul_iter_pkg.sv | 31 +++
 rtl/mul_iter_add64_cla.sv | 57 +++++
 rtl/mul_iter.sv | 193 +++++++++++++++++++
 tb/tb_mul_iter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mul_iter_pkg.sv
// mul_iter_pkg
//   Shared definitions for the iterative multiplier: operation encodings,
//   FSM state encodings, step counts and a small magnitude helper.
//   No ports (package).
package mul_iter_pkg;

   // Operation encodings on the op input
   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;
   localparam logic [1:0] OP_MULHU  = 2'b11;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Iteration counter: holds 0..64
   localparam int unsigned CNT_W = 7;
   localparam logic [CNT_W-1:0] STEPS_D = 7'd64;  // full 64x64
   localparam logic [CNT_W-1:0] STEPS_W = 7'd32;  // MULW

   // Two's-complement magnitude. For the most-negative value the result is
   // 0x8000_0000_0000_0000, which is exact when read as unsigned.
   function automatic logic [63:0] magnitude(input logic [63:0] v, input logic neg);
      return neg ? (~v + 64'd1) : v;
   endfunction

endpackage

// File: rtl/mul_iter_add64_cla.sv
// cla4 / add64_cla
//   cla4      : 4-bit carry-lookahead adder unit.
//   add64_cla : 64-bit adder built from sixteen cla4 units with the block
//               carries chained between units.
//   Ports (add64_cla):
//     x, y  : 64-bit addends
//     cin   : carry in
//     f     : 64-bit sum
//     cout  : carry out of bit 63
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      s    = p ^ c[3:0];
      cout = c[4];
   end
endmodule

module add64_cla (
   input  logic [63:0] x,
   input  logic [63:0] y,
   input  logic        cin,
   output logic [63:0] f,
   output logic        cout
);
   logic [16:0] blk_c;

   assign blk_c[0] = cin;

   for (genvar gi = 0; gi < 16; gi++) begin : g_blk
      cla4 u_cla4 (
         .a    (x[gi*4 +: 4]),
         .b    (y[gi*4 +: 4]),
         .cin  (blk_c[gi]),
         .s    (f[gi*4 +: 4]),
         .cout (blk_c[gi+1])
      );
   end

   assign cout = blk_c[16];
endmodule

// File: rtl/mul_iter.sv
// mul_iter
//   Iterative radix-2 shift-add multiplier (RISC-V M style MUL/MULH/MULHSU/
//   MULHU/MULW). Operates on magnitudes, applies sign correction at the end.
//   XLEN is the operand/result width; the datapath is built for 64.
//   Ports:
//     clock, reset        : rising-edge clock, asynchronous active-high reset
//     in_valid / in_ready : request handshake (in_ready only in IDLE)
//     op, word            : operation select, word=1 selects MULW
//     src1, src2          : multiplicand, multiplier
//     flush               : abort, returns to IDLE on next edge
//     out_valid/out_ready : result handshake
//     result              : registered result
module mul_iter
   import mul_iter_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic            word,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q;
   logic [1:0]         op_q;
   logic               word_q;
   logic               neg_q;
   logic [63:0]        mcand_q;   // multiplicand magnitude
   logic [63:0]        acc_q;     // upper half of the running product
   logic [63:0]        mplier_q;  // multiplier, shifts out as product fills in
   logic [63:0]        result_q;

   logic               accept;
   logic               final_step;

   // ------------------------------------------------------------------
   // Operand preparation (used only on the accept edge)
   // ------------------------------------------------------------------
   logic [63:0] a_ext, b_ext, mag1, mag2;
   logic        signed1, signed2, neg1, neg2;

   always_comb begin
      a_ext   = word ? {{32{src1[31]}}, src1[31:0]} : src1;
      b_ext   = word ? {{32{src2[31]}}, src2[31:0]} : src2;
      // MULW is always signed x signed regardless of op
      signed1 = word || (op != OP_MULHU);
      signed2 = word || (op == OP_MUL) || (op == OP_MULH);
      neg1    = signed1 && a_ext[63];
      neg2    = signed2 && b_ext[63];
      mag1    = magnitude(a_ext, neg1);
      mag2    = magnitude(b_ext, neg2);
   end

   // ------------------------------------------------------------------
   // Shared adder: accumulate during steps, low-half negate on the final
   // cycle (~lo + 1); the carry out feeds the high-half increment.
   // ------------------------------------------------------------------
   logic [63:0] prod_lo, prod_hi;
   logic [63:0] add_x, add_y, add_f;
   logic        add_cin, add_cout;
   logic [63:0] fin_lo, fin_hi, res_sel;

   assign final_step = (state_q == ST_BUSY) && (count_q == '0);

   always_comb begin
      // After 32 steps a 32x32 product sits at bits [95:32] of {acc, mplier}
      if (word_q) begin
         prod_lo = {acc_q[31:0], mplier_q[63:32]};
         prod_hi = 64'd0;
      end else begin
         prod_lo = mplier_q;
         prod_hi = acc_q;
      end

      if (final_step) begin
         add_x   = ~prod_lo;
         add_y   = 64'd0;
         add_cin = 1'b1;
      end else begin
         add_x   = acc_q;
         add_y   = mplier_q[0] ? mcand_q : 64'd0;
         add_cin = 1'b0;
      end
   end

   add64_cla u_add (
      .x    (add_x),
      .y    (add_y),
      .cin  (add_cin),
      .f    (add_f),
      .cout (add_cout)
   );

   always_comb begin
      fin_lo = neg_q ? add_f : prod_lo;
      fin_hi = neg_q ? (~prod_hi + {63'd0, add_cout}) : prod_hi;
      if (word_q)
         res_sel = {{32{fin_lo[31]}}, fin_lo[31:0]};
      else if (op_q == OP_MUL)
         res_sel = fin_lo;
      else
         res_sel = fin_hi;
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   assign accept = in_valid && (state_q == ST_IDLE) && !flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // FSM: next state (flush overrides everything)
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: if (accept)        state_d = ST_BUSY;
            ST_BUSY: if (count_q == '0) state_d = ST_DONE;
            ST_DONE: if (out_ready)     state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
         endcase
      end
   end

   // FSM: outputs (decoded from the state register only)
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   assign result = result_q;

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q  <= '0;
         op_q     <= OP_MUL;
         word_q   <= 1'b0;
         neg_q    <= 1'b0;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         result_q <= '0;
      end else if (flush) begin
         count_q  <= '0;
         result_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q     <= op;
                  word_q   <= word;
                  neg_q    <= neg1 ^ neg2;
                  mcand_q  <= mag1;
                  mplier_q <= mag2;
                  acc_q    <= '0;
                  count_q  <= word ? STEPS_W : STEPS_D;
               end
            end
            ST_BUSY: begin
               if (count_q != '0) begin
                  // Shift {cout, sum, mplier} right by one
                  acc_q    <= {add_cout, add_f[63:1]};
                  mplier_q <= {add_f[0], mplier_q[63:1]};
                  count_q  <= count_q - 1'b1;
               end else begin
                  result_q <= res_sel;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter
//   Directed testbench for mul_iter: hand-computed products, latency,
//   flush/reset abort and output back-pressure.
module tb_mul_iter;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic        word;
   logic [63:0] src1;
   logic [63:0] src2;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;

   int n_checks = 0;
   int n_pass   = 0;

   mul_iter #(.XLEN(64)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .word      (word),
      .src1      (src1),
      .src2      (src2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %s got=0x%016h", tag, got);
      end else begin
         $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
      end
   endtask

   // Issue one request, wait for out_valid, check latency/result, handshake.
   task automatic run_op(input string tag, input logic [1:0] o, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int lat);
      int k;
      bit seen;
      @(negedge clock);
      check({tag, "/in_ready"}, {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1; op = o; word = w; src1 = a; src2 = b;
      @(posedge clock); #1;
      // Keep in_valid high with different operands: must be ignored
      src1 = ~a; src2 = a ^ b; op = ~o; word = ~w;
      k = 0; seen = 0;
      for (int i = 1; i <= lat + 5 && !seen; i++) begin
         @(posedge clock); #1;
         if (out_valid) begin
            seen = 1;
            k = i;
         end
      end
      in_valid = 1'b0;
      check({tag, "/latency"}, 64'(k), 64'(lat));
      check({tag, "/result"}, result, exp);
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      check({tag, "/out_valid_drop"}, {63'd0, out_valid}, 64'd0);
      check({tag, "/in_ready_back"}, {63'd0, in_ready}, 64'd1);
   endtask

   // Start an operation and return right after the accept edge (+1).
   task automatic start_op(input logic [63:0] a, input logic [63:0] b);
      @(negedge clock);
      in_valid = 1'b1; op = 2'b00; word = 1'b0; src1 = a; src2 = b;
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   // Watch out_valid for n cycles; returns the number of cycles it was high.
   task automatic watch_quiet(input int n, output int hits);
      hits = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         if (out_valid) hits++;
      end
   endtask

   initial begin
      int hits;
      reset = 1'b1; in_valid = 1'b0; op = 2'b00; word = 1'b0;
      src1 = '0; src2 = '0; flush = 1'b0; out_ready = 1'b0;

      repeat (2) @(posedge clock);
      #1;
      check("reset/out_valid", {63'd0, out_valid}, 64'd0);
      check("reset/result", result, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("reset/in_ready", {63'd0, in_ready}, 64'd1);

      // Directed vectors
      run_op("mul_3x5",        2'b00, 1'b0, 64'd3, 64'd5, 64'd15, 65);
      run_op("mulh_m1xm1",     2'b01, 1'b0, '1, '1, 64'd0, 65);
      run_op("mulhu_m1xm1",    2'b11, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      run_op("mul_m1xm1",      2'b00, 1'b0, '1, '1, 64'd1, 65);
      run_op("mulhsu_m1x2",    2'b10, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      run_op("mulh_minxm1",    2'b01, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 65);
      run_op("mul_minxm1",     2'b00, 1'b0, 64'h8000_0000_0000_0000, '1,
             64'h8000_0000_0000_0000, 65);
      run_op("mulw_7fffffffx2", 2'b00, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFE, 33);
      run_op("mulw_m3x7",      2'b00, 1'b1, 64'h1234_5678_FFFF_FFFD, 64'hABCD_0000_0000_0007,
             64'hFFFF_FFFF_FFFF_FFEB, 33);
      run_op("mulhu_m1x2",     2'b11, 1'b0, '1, 64'd2, 64'd1, 65);
      run_op("mulh_m5x3",      2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3,
             64'hFFFF_FFFF_FFFF_FFFF, 65);
      run_op("mul_m5x3",       2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3,
             64'hFFFF_FFFF_FFFF_FFF1, 65);

      // Flush at BUSY cycle 10
      start_op(64'd6, 64'd7);
      repeat (9) @(posedge clock);
      @(negedge clock);
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      check("flush/in_ready", {63'd0, in_ready}, 64'd1);
      check("flush/out_valid", {63'd0, out_valid}, 64'd0);
      watch_quiet(70, hits);
      check("flush/no_pulse", 64'(hits), 64'd0);

      // Reset mid-BUSY
      start_op(64'd6, 64'd7);
      repeat (20) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("rst_busy/out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_busy/result", result, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst_busy/in_ready", {63'd0, in_ready}, 64'd1);
      watch_quiet(70, hits);
      check("rst_busy/no_pulse", 64'(hits), 64'd0);

      // Back-pressure: out_ready low for 5 cycles in DONE
      start_op(64'd6, 64'd7);
      repeat (64) @(posedge clock);
      #1;
      check("stall/not_yet", {63'd0, out_valid}, 64'd0);
      @(posedge clock); #1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stall/valid%0d", i), {63'd0, out_valid}, 64'd1);
         check($sformatf("stall/result%0d", i), result, 64'd42);
         @(posedge clock); #1;
      end
      check("stall/still_valid", {63'd0, out_valid}, 64'd1);
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      check("stall/out_valid_drop", {63'd0, out_valid}, 64'd0);
      check("stall/in_ready", {63'd0, in_ready}, 64'd1);

      // Flush in DONE wins over out_ready and discards the result
      start_op(64'd9, 64'd9);
      repeat (65) @(posedge clock);
      #1;
      check("flush_done/valid", {63'd0, out_valid}, 64'd1);
      check("flush_done/result", result, 64'd81);
      @(negedge clock);
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0; out_ready = 1'b0;
      check("flush_done/out_valid", {63'd0, out_valid}, 64'd0);
      check("flush_done/result0", result, 64'd0);
      check("flush_done/in_ready", {63'd0, in_ready}, 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
